// File: rtl/modified_peres_unit.sv
// Registered bit-parallel array of modified Peres gates (C tied to 0): P = A, Q = A ^ B, R = A & B.
// Define MODIFIED_PERES_PIPE2_EN to add a second output register stage (2-cycle latency).
module modified_peres_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R
);

  logic [WIDTH-1:0] p_d, q_d, r_d;
  logic [WIDTH-1:0] p_q, q_q, r_q;

  // Q/R form a per-bit half adder; P carries A so the gate stays reversible.
  always_comb begin
    p_d = A;
    q_d = A ^ B;
    r_d = A & B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      q_q <= '0;
      r_q <= '0;
    end else begin
      p_q <= p_d;
      q_q <= q_d;
      r_q <= r_d;
    end
  end

`ifdef MODIFIED_PERES_PIPE2_EN
  logic [WIDTH-1:0] p2_q, q2_q, r2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_q <= '0;
      q2_q <= '0;
      r2_q <= '0;
    end else begin
      p2_q <= p_q;
      q2_q <= q_q;
      r2_q <= r_q;
    end
  end

  assign P = p2_q;
  assign Q = q2_q;
  assign R = r2_q;
`else
  assign P = p_q;
  assign Q = q_q;
  assign R = r_q;
`endif

endmodule

// File: tb/tb_modified_peres_unit.sv
// Scoreboard bench for modified_peres_unit: expected results queued at drive time, popped after each edge.
module tb_modified_peres_unit;

  localparam int W = 32;
`ifdef MODIFIED_PERES_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic [W-1:0] A_s, B_s;
  logic [W-1:0] P_s, Q_s, R_s;

  int checks;
  int failures;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;

  exp_t sb[$];

  modified_peres_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A_s),
    .B    (B_s),
    .P    (P_s),
    .Q    (Q_s),
    .R    (R_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results still in the pipeline right after reset are zeros.
  task automatic model_reset();
    exp_t z;
    z = '0;
    sb.delete();
    for (int i = 0; i < LAT - 1; i++) sb.push_back(z);
  endtask

  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ep, input logic [W-1:0] eq,
                      input logic [W-1:0] er, input string tag);
    exp_t e, got;
    @(negedge clk);
    A_s = a;
    B_s = b;
    e.a = a; e.b = b; e.p = ep; e.q = eq; e.r = er;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty got=0 required=1", tag);
      return;
    end
    got = sb.pop_front();
    checks++;
    if (P_s !== got.p) begin
      failures++;
      $display("FAIL %s P actual=%08h required=%08h", tag, P_s, got.p);
    end
    checks++;
    if (Q_s !== got.q) begin
      failures++;
      $display("FAIL %s Q actual=%08h required=%08h", tag, Q_s, got.q);
    end
    checks++;
    if (R_s !== got.r) begin
      failures++;
      $display("FAIL %s R actual=%08h required=%08h", tag, R_s, got.r);
    end
    checks++;
    if ((P_s ^ Q_s) !== got.b) begin
      failures++;
      $display("FAIL %s inv_pq actual=%08h required=%08h", tag, P_s ^ Q_s, got.b);
    end
    checks++;
    if ((Q_s & R_s) !== '0) begin
      failures++;
      $display("FAIL %s inv_qr_and actual=%08h required=00000000", tag, Q_s & R_s);
    end
    checks++;
    if ((Q_s | R_s) !== (got.a | got.b)) begin
      failures++;
      $display("FAIL %s inv_qr_or actual=%08h required=%08h", tag, Q_s | R_s, got.a | got.b);
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (P_s !== '0 || Q_s !== '0 || R_s !== '0) begin
      failures++;
      $display("FAIL %s PQR actual=%08h/%08h/%08h required=0/0/0", tag, P_s, Q_s, R_s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    A_s = '1;
    B_s = '1;
    #1;
    check_zero("reset_immediate");
    @(posedge clk);
    #1;
    check_zero("reset_held_edge");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, "reset_first_capture");
  endtask

  task automatic test_patterns();
    step(32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h00000000, "a5_5a");
    step(32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "ones_zeros");
    step(32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, "zeros_ones");
    step(32'h12345678, 32'h87654321, 32'h12345678, 32'h95511559, 32'h02244220, "mixed");
    step(32'h3C3C00FF, 32'h3C3C00FF, 32'h3C3C00FF, 32'h00000000, 32'h3C3C00FF, "a_eq_b");
    step(32'h0000FFFF, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 32'h00000000, "a_not_b");
  endtask

  task automatic test_back_to_back();
    step(32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h00000000, "b2b_first");
    step(32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h00000000, "b2b_second");
    step(32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, "b2b_flush");
  endtask

  task automatic test_reset_midstream();
    step(32'hDEADBEEF, 32'h0BADF00D, 32'hDEADBEEF, 32'hDEADBEEF ^ 32'h0BADF00D,
         32'hDEADBEEF & 32'h0BADF00D, "pre_reset");
    @(negedge clk);
    A_s = 32'hCAFEF00D;
    B_s = 32'h13579BDF;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async_drop");
    @(posedge clk);
    #1;
    check_zero("reset_discard_inflight");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(32'h00FF00FF, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FF00FF0, 32'h000F000F, "post_reset");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 10000; i++) begin
      a = $urandom();
      b = $urandom();
      step(a, b, a, a ^ b, a & b, "random");
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    A_s = '0;
    B_s = '0;
    test_reset();
    test_patterns();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
